// File: rtl/serial_word_feeder_pkg.sv
// Shared types and helpers for the serial word feeder and its mod-3 tracker.
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } feeder_state_t;

    localparam int FEEDER_DEFAULT_WIDTH = 20;

    // Next remainder after appending one bit: (2r + b) mod 3, never yields 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd0:    n = {1'b0, b};
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/serial_word_feeder_mod3_tracker.sv
// Running mod-3 remainder of an MSB-first bit stream, with synchronous clear.
module mod3_tracker
    import feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [1:0] o_rem
);

    logic [1:0] r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 2'd0;
        end else if (i_clr) begin
            r_rem <= 2'd0;
        end else if (i_en) begin
            r_rem <= mod3_step(r_rem, i_bit);
        end
    end

    assign o_rem = r_rem;

endmodule

// File: rtl/serial_word_feeder.sv
// Serialises a parallel word MSB-first to the mod-3 stage and cross-checks
// the downstream remainder against an internal tracker.
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH = FEEDER_DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             data,
    output logic             data_valid,
    output logic             sof,
    output logic             eof,
    output logic             ds_clr,
    input  logic             div_in,
    input  logic [1:0]       rem_in,
    output logic             result_valid,
    output logic [1:0]       result_rem,
    output logic             result_div,
    output logic             mismatch
);

    localparam int CNT_W = $clog2(WIDTH);

    feeder_state_t    r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_data;
    logic             r_dvalid;
    logic             r_sof;
    logic             r_eof;
    logic             r_ds_clr;
    logic             r_rvalid;
    logic [1:0]       r_rrem;
    logic             r_rdiv;
    logic             r_mismatch;

    logic             w_accept;
    logic [1:0]       w_trk;

    // Ready is only ever high in IDLE or CAPTURE, so this is the handshake edge.
    assign w_accept = word_valid && r_ready;

    mod3_tracker u_trk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (r_state == ST_SHIFT),
        .i_bit (r_data),
        .o_rem (w_trk)
    );

    // Shift register carries the bits still to be sent; data path needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sreg <= word_in << 1;
        end else if (r_state == ST_SHIFT) begin
            r_sreg <= r_sreg << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_data     <= 1'b0;
            r_dvalid   <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_ds_clr   <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rrem     <= 2'd0;
            r_rdiv     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_CAPTURE: begin
                    if (w_accept) begin
                        r_state  <= ST_SHIFT;
                        r_ready  <= 1'b0;
                        r_ds_clr <= 1'b0;
                        r_data   <= word_in[WIDTH-1];
                        r_dvalid <= 1'b1;
                        r_sof    <= 1'b1;
                        r_eof    <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                    end else begin
                        r_state  <= ST_IDLE;
                        r_ready  <= 1'b1;
                        r_ds_clr <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_sof <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state  <= ST_WAIT;
                        r_data   <= 1'b0;
                        r_dvalid <= 1'b0;
                        r_eof    <= 1'b0;
                    end else begin
                        r_data <= r_sreg[WIDTH-1];
                        r_eof  <= (r_cnt == CNT_W'(1));
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // Downstream took the LSB on the edge into WAIT; its result is stable now.
                    r_state    <= ST_CAPTURE;
                    r_rrem     <= rem_in;
                    r_rdiv     <= div_in;
                    r_mismatch <= (rem_in != w_trk) || (div_in != (w_trk == 2'd0));
                    r_rvalid   <= 1'b1;
                    r_ready    <= 1'b1;
                    r_ds_clr   <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_ready   = r_ready;
    assign data         = r_data;
    assign data_valid   = r_dvalid;
    assign sof          = r_sof;
    assign eof          = r_eof;
    assign ds_clr       = r_ds_clr;
    assign result_valid = r_rvalid;
    assign result_rem   = r_rrem;
    assign result_div   = r_rdiv;
    assign mismatch     = r_mismatch;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder with a behavioural mod-3 downstream stage.
module tb_serial_word_feeder;

    localparam int W = 20;

    typedef struct {
        logic [W-1:0] w;
        logic [1:0]   rem;
        logic         div;
        logic         mis;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready, data, data_valid, sof, eof, ds_clr;
    logic         div_in;
    logic [1:0]   rem_in;
    logic         result_valid;
    logic [1:0]   result_rem;
    logic         result_div;
    logic         mismatch;

    logic [1:0]   ds_rem;
    logic         force_bad = 1'b0;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           bitidx = 0;
    logic [W-1:0] cur = '0;
    int           clr_run = 0;
    int           last_gap = 0;
    int           last_acc = 0;

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .data         (data),
        .data_valid   (data_valid),
        .sof          (sof),
        .eof          (eof),
        .ds_clr       (ds_clr),
        .div_in       (div_in),
        .rem_in       (rem_in),
        .result_valid (result_valid),
        .result_rem   (result_rem),
        .result_div   (result_div),
        .mismatch     (mismatch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream divisibility stage model.
    always @(posedge clk) begin
        if (ds_clr) ds_rem <= 2'd0;
        else if (data_valid) ds_rem <= 2'((2 * int'(ds_rem) + int'(data)) % 3);
    end
    assign rem_in = force_bad ? 2'd2 : ds_rem;
    assign div_in = force_bad ? 1'b0 : (ds_rem == 2'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: bit stream and results against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (bitidx == 0) last_gap = clr_run;
                clr_run = 0;
                if (exp_q.size() == 0 || bitidx >= W) begin
                    chk("unexpected_bit", 32'(bitidx), 32'(W));
                end else begin
                    chk("data", 32'(data), 32'(exp_q[0].w[W-1-bitidx]));
                    chk("sof", 32'(sof), 32'(bitidx == 0));
                    chk("eof", 32'(eof), 32'(bitidx == W-1));
                    cur = {cur[W-2:0], data};
                    bitidx++;
                    if (bitidx == W) begin
                        chk("word", 32'(cur), 32'(exp_q[0].w));
                        bitidx = 0;
                    end
                end
            end else if (ds_clr) begin
                clr_run++;
            end
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(result_valid), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rem", 32'(result_rem), 32'(e.rem));
                    chk("div", 32'(result_div), 32'(e.div));
                    chk("mismatch", 32'(mismatch), 32'(e.mis));
                    chk("latency", 32'(cyc - e.acc), 32'(W + 1));
                    chk("ready_with_result", 32'(word_ready), 32'(1));
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit bad_ds, input bit hold);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        word_in    = w;
        word_valid = 1'b1;
        while (!word_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) begin
            chk("accept_timeout", 32'(word_ready), 32'(1));
            word_valid = 1'b0;
            return;
        end
        e.w   = w;
        e.rem = bad_ds ? 2'd2 : 2'(int'(w) % 3);
        e.div = bad_ds ? 1'b0 : ((int'(w) % 3) == 0);
        e.mis = bad_ds;
        e.acc = cyc + 1;
        last_acc = e.acc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) word_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(word_ready), 32'(0));
        chk({tag, "_data"}, 32'(data), 32'(0));
        chk({tag, "_dvalid"}, 32'(data_valid), 32'(0));
        chk({tag, "_sof_eof"}, 32'({sof, eof}), 32'(0));
        chk({tag, "_ds_clr"}, 32'(ds_clr), 32'(1));
        chk({tag, "_result"}, 32'({result_valid, result_rem, result_div, mismatch}), 32'(0));
    endtask

    initial begin
        int a1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(word_ready), 32'(1));

        send(20'h00007, 1'b0, 1'b0);
        drain();
        send(20'h00003, 1'b0, 1'b0);
        drain();
        send(20'hFFFFF, 1'b0, 1'b0);
        drain();

        send(20'h00005, 1'b0, 1'b1);
        a1 = last_acc;
        send(20'h00004, 1'b0, 1'b0);
        chk("b2b_gap", 32'(last_acc - a1), 32'(W + 2));
        drain();
        chk("b2b_clr_cycles", 32'(last_gap), 32'(1));

        // Reset in the middle of a word.
        send(20'h12345, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (bitidx >= 7) break;
        end
        chk("bits_before_reset", 32'(bitidx), 32'(7));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        void'(exp_q.pop_front());
        bitidx = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_result_in_reset", 32'(result_valid), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", 32'(word_ready), 32'(1));
        send(20'h00006, 1'b0, 1'b0);
        drain();

        force_bad = 1'b1;
        send(20'h00009, 1'b1, 1'b0);
        drain();
        force_bad = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] rw;
            rw = W'($urandom);
            send(rw, 1'b0, (i % 3) == 0);
        end
        word_valid = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
